noc_rr_arbiter_p: RTL and testbench
===================================

# noc_rr_arbiter_p

Parametrised switch allocator for the 5-port (N, S, W, E, L) mesh router. Each input port latches a dimension-ordered next hop from its header, either YX or XY as selected by a parameter. One round-robin arbiter per output grants that output to a single waiting input and locks it until the packet tail releases it. It sits between the input buffers and the crossbar switch; its grant vector drives the crossbar selects directly.

## Interface
Parameters:
- COORD_W, default 4: width of each X and Y coordinate. The address is {Y, X}, so ADDR_W = 2*COORD_W.
- ROUTE_YX, default 1: selects the routing order. 1 = YX (Y resolved first), 0 = XY.
- Port index is fixed: 0=N, 1=S, 2=W, 3=E, 4=L. NUM_PORTS = 5 (localparam).

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- router_addr_i, in, ADDR_W: this router's {Y, X}. Quasi-static.
- req_i, in, 5: per-input request. Held high while the header is valid and until a grant is received.
- hdr_addr_i, in, 5*ADDR_W: per-input destination {Y, X}. Slice i is [i*ADDR_W +: ADDR_W].
- release_i, in, 5: per-input tail-flit-sent pulse. Frees the output held by that input.
- gnt_o, out, 25: grant matrix. Bit o*5+i set means output o is granted to input i. One-hot or zero per output.
- in_granted_o, out, 5: input i currently holds an output.
- out_busy_o, out, 5: output o is locked.
- route_err_o, out, 5: sticky per input. Set when a computed route is a U-turn (output index == input index, for any input except L). Cleared only by reset.

## Operation
- Route function, combinational, one per input, given dest {dy, dx} and router {ry, rx}:
  - YX mode: dy>ry → N; dy<ry → S; else dx>rx → E; dx<rx → W; else L.
  - XY mode: X compared first, then Y, with the same direction mapping.
  - Comparisons are unsigned over COORD_W bits.
- Per-input FSM:
  - IDLE: if req_i[i] is set, latch the route into a 3-bit next-hop register and go to WAIT.
    - If that route is a U-turn, set route_err_o[i] and stay IDLE. The request is dropped, and req_i must fall before it is re-sampled.
  - WAIT: if req_i[i] falls, go to IDLE (abort, no grant). If the output grants this input, go to ACTIVE.
  - ACTIVE: in_granted_o[i]=1. On release_i[i], go to IDLE and free the output. req_i is ignored while in ACTIVE.
- Per-output arbiter:
  - Holds busy flag, owner index (3b) and RR pointer (3b).
  - When not busy, candidates are the inputs in WAIT whose next hop is this output and whose req_i is still high.
  - The winner is the first candidate searched from (ptr+1) mod 5 upward, with wrap.
  - On a grant: busy=1, owner=winner, ptr=winner.
  - The pointer changes only on a grant. Release does not move it.
- At most one grant per output per cycle. One input can be waiting on only one output, so no input is ever granted twice.
- release_i on an input that is not ACTIVE is ignored.

## Timing
- Reset values:
  - gnt_o=0, in_granted_o=0, out_busy_o=0, route_err_o=0.
  - All input FSMs in IDLE, all next-hop registers 0.
  - All RR pointers = 4, so the first search starts at index 0 (N).
- req_i rises in cycle t → WAIT from edge t+1 → grant registered at edge t+2. gnt_o, in_granted_o and out_busy_o are high in cycle t+2 (2-cycle minimum latency).
- release_i high in cycle t → gnt_o bit, in_granted_o and out_busy_o drop at edge t+1. The earliest new grant of that output is at edge t+2, giving one dead cycle.
- req_i falling in the same cycle a grant would be evaluated: no grant is issued and the input returns to IDLE. req_i is sampled before arbitration.
- Simultaneous release and new request on the same input: the release wins. The FSM goes to IDLE, and the request is sampled from cycle t+1.
- Reset asserted mid-packet: all outputs clear immediately (asynchronously). After deassertion, held requests restart from IDLE at the first clock.
- router_addr_i and hdr_addr_i are sampled only in IDLE. Changes during WAIT or ACTIVE have no effect.

## Test plan
- Reset and single route: COORD_W=4, YX, router {2,2}, input L header {3,1}, req at t0. Required: route N, gnt_o[0*5+4]=1 at t0+2, out_busy_o=5'b00001. Pulse release → all zero one cycle later.
- Round-robin fairness: inputs S, W, E, L all target N (headers {3,2} at router {2,2}), requests held and each packet released after 1 cycle. Required grant order after reset: S, W, E, L, then S again, each separated by one dead cycle.
- XY vs YX: router {2,2}, header {3,3}. ROUTE_YX=1 → output N. ROUTE_YX=0 → output E.
- U-turn: input N with a header that routes N. Required: route_err_o[0]=1 sticky, no gnt_o bit ever set, in_granted_o[0]=0.
- Abort and lock: W waiting on E while L owns E. Drop W's req → W back in IDLE. L releases → E stays free and no grant to W.
- Async reset mid-packet: reset low while two outputs are busy. Required: gnt_o=0 and out_busy_o=0 before the next clk edge. After reset rises, a held request is granted at edge +2.

Source files
------------

// File: rtl/noc_rr_arbiter_p.sv
// noc_rr_arbiter_p
// Switch allocator for a 5-port (N, S, W, E, L) mesh router. Each input
// latches a dimension-ordered next hop from its header (YX or XY). One
// round-robin arbiter per output grants the output to one waiting input and
// keeps it locked until that input's tail release.
//
// Ports
//   clk            clock
//   reset          asynchronous active-low reset
//   router_addr_i  this router's {Y, X}
//   req_i          per-input request, held until granted
//   hdr_addr_i     per-input destination {Y, X}, slice i = [i*ADDR_W +: ADDR_W]
//   release_i      per-input tail-sent pulse
//   gnt_o          grant matrix, bit o*5+i = output o granted to input i
//   in_granted_o   input i currently holds an output
//   out_busy_o     output o is locked
//   route_err_o    sticky per-input U-turn flag
//
// Input FSM
//   state     | meaning
//   IN_IDLE   | no request latched; samples req_i and the header route
//   IN_WAIT   | next hop latched, competing for that output
//   IN_ACTIVE | owns its output until release_i
//
// Port index: 0=N 1=S 2=W 3=E 4=L. RR pointers reset to 4 so the first
// search starts at N.

module noc_rr_arbiter_p #(
  parameter int COORD_W  = 4,
  parameter int ROUTE_YX = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*COORD_W-1:0]     router_addr_i,
  input  logic [4:0]               req_i,
  input  logic [5*2*COORD_W-1:0]   hdr_addr_i,
  input  logic [4:0]               release_i,
  output logic [24:0]              gnt_o,
  output logic [4:0]               in_granted_o,
  output logic [4:0]               out_busy_o,
  output logic [4:0]               route_err_o
);

  localparam int ADDR_W    = 2 * COORD_W;
  localparam int NUM_PORTS = 5;

  localparam logic [2:0] DIR_N = 3'd0;
  localparam logic [2:0] DIR_S = 3'd1;
  localparam logic [2:0] DIR_W = 3'd2;
  localparam logic [2:0] DIR_E = 3'd3;
  localparam logic [2:0] DIR_L = 3'd4;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_WAIT,
    IN_ACTIVE
  } in_state_t;

  in_state_t            state_q [NUM_PORTS];
  in_state_t            state_d [NUM_PORTS];
  logic [2:0]           hop_q   [NUM_PORTS];
  logic [2:0]           hop_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] blk_q, blk_d;
  logic [NUM_PORTS-1:0] err_q, err_d;

  logic                 busy_q  [NUM_PORTS];
  logic                 busy_d  [NUM_PORTS];
  logic [2:0]           owner_q [NUM_PORTS];
  logic [2:0]           owner_d [NUM_PORTS];
  logic [2:0]           ptr_q   [NUM_PORTS];
  logic [2:0]           ptr_d   [NUM_PORTS];

  logic [2:0]           route   [NUM_PORTS];
  logic [NUM_PORTS-1:0] uturn;
  logic [NUM_PORTS-1:0] cand    [NUM_PORTS];
  logic [NUM_PORTS-1:0] granted_in;

  function automatic logic [2:0] route_fn(
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] ry,
    input logic [COORD_W-1:0] rx
  );
    logic [2:0] y_hop;
    logic [2:0] x_hop;
    logic [2:0] hop;
    y_hop = (dy > ry) ? DIR_N : DIR_S;
    x_hop = (dx > rx) ? DIR_E : DIR_W;
    hop   = DIR_L;
    if (ROUTE_YX != 0) begin
      if (dy != ry)      hop = y_hop;
      else if (dx != rx) hop = x_hop;
    end else begin
      if (dx != rx)      hop = x_hop;
      else if (dy != ry) hop = y_hop;
    end
    return hop;
  endfunction

  // Route and U-turn detection per input; a local packet arriving on L is
  // legal, so L is excluded from the U-turn test.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = route_fn(hdr_addr_i[i*ADDR_W + COORD_W +: COORD_W],
                          hdr_addr_i[i*ADDR_W +: COORD_W],
                          router_addr_i[ADDR_W-1:COORD_W],
                          router_addr_i[COORD_W-1:0]);
      uturn[i] = (route[i] == 3'(i)) && (i != NUM_PORTS - 1);
    end
  end

  // Candidates use the live req_i so a request dropped this cycle never wins.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = (state_q[i] == IN_WAIT) && (hop_q[i] == 3'(o)) && req_i[i];
      end
    end
  end

  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    granted_in = '0;
    sum        = '0;
    idx        = '0;
    win        = '0;
    found      = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      busy_d[o]  = busy_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      found      = 1'b0;
      win        = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
        sum = {1'b0, ptr_q[o]} + 4'(k);
        if (sum >= 4'd5) sum = sum - 4'd5;
        idx = sum[2:0];
        if (!found && cand[o][idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (busy_q[o]) begin
        // Owner is always ACTIVE while the output is busy.
        if (release_i[owner_q[o]]) busy_d[o] = 1'b0;
      end else if (found) begin
        busy_d[o]       = 1'b1;
        owner_d[o]      = win;
        ptr_d[o]        = win;
        granted_in[win] = 1'b1;
      end
    end
  end

  always_comb begin
    blk_d = blk_q & req_i;  // a dropped U-turn request re-arms once req falls
    err_d = err_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i] = state_q[i];
      hop_d[i]   = hop_q[i];
      case (state_q[i])
        IN_IDLE: begin
          if (req_i[i] && !blk_q[i]) begin
            if (uturn[i]) begin
              err_d[i] = 1'b1;
              blk_d[i] = 1'b1;
            end else begin
              hop_d[i]   = route[i];
              state_d[i] = IN_WAIT;
            end
          end
        end
        IN_WAIT: begin
          if (!req_i[i])          state_d[i] = IN_IDLE;
          else if (granted_in[i]) state_d[i] = IN_ACTIVE;
        end
        IN_ACTIVE: begin
          if (release_i[i]) state_d[i] = IN_IDLE;
        end
        default: state_d[i] = IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q <= '0;
      err_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= IN_IDLE;
        hop_q[i]   <= '0;
        busy_q[i]  <= 1'b0;
        owner_q[i] <= '0;
        ptr_q[i]   <= 3'd4;
      end
    end else begin
      blk_q <= blk_d;
      err_q <= err_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= state_d[i];
        hop_q[i]   <= hop_d[i];
        busy_q[i]  <= busy_d[i];
        owner_q[i] <= owner_d[i];
        ptr_q[i]   <= ptr_d[i];
      end
    end
  end

  always_comb begin
    gnt_o        = '0;
    in_granted_o = '0;
    out_busy_o   = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_busy_o[o]   = busy_q[o];
      in_granted_o[o] = (state_q[o] == IN_ACTIVE);
      if (busy_q[o]) gnt_o[o*NUM_PORTS + int'(owner_q[o])] = 1'b1;
    end
  end

  assign route_err_o = err_q;

endmodule

// File: tb/tb_noc_rr_arbiter_p.sv
module tb_noc_rr_arbiter_p;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  router;
  logic [4:0]  req;
  logic [39:0] hdr;
  logic [4:0]  rel;

  logic [24:0] gnt_yx, gnt_xy;
  logic [4:0]  ing_yx, ing_xy, busy_yx, busy_xy, err_yx, err_xy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  noc_rr_arbiter_p #(.COORD_W(4), .ROUTE_YX(1)) dut_yx (
    .clk(clk), .reset(reset), .router_addr_i(router), .req_i(req),
    .hdr_addr_i(hdr), .release_i(rel), .gnt_o(gnt_yx),
    .in_granted_o(ing_yx), .out_busy_o(busy_yx), .route_err_o(err_yx));

  noc_rr_arbiter_p #(.COORD_W(4), .ROUTE_YX(0)) dut_xy (
    .clk(clk), .reset(reset), .router_addr_i(router), .req_i(req),
    .hdr_addr_i(hdr), .release_i(rel), .gnt_o(gnt_xy),
    .in_granted_o(ing_xy), .out_busy_o(busy_xy), .route_err_o(err_xy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    req    = '0;
    rel    = '0;
    hdr    = '0;
    router = 8'h22;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_hdr(input int i, input logic [7:0] yx);
    hdr[i*8 +: 8] = yx;
  endtask

  // out code 7 marks a U-turn: no grant, error bit for that input
  function automatic logic [31:0] exp_gnt(input int out, input int inp);
    return (out == 7) ? 32'd0 : (32'd1 << (out*5 + inp));
  endfunction

  function automatic logic [31:0] exp_err(input int out, input int inp);
    return (out == 7) ? (32'd1 << inp) : 32'd0;
  endfunction

  // ---------------- reference model (index 0 = YX, 1 = XY) ----------------
  int m_st  [2][5];   // 0 idle, 1 waiting, 2 active
  int m_hop [2][5];
  int m_own [2][5];
  int m_ptr [2][5];
  bit m_blk [2][5];
  bit m_err [2][5];
  bit m_busy[2][5];

  function automatic int ref_route(input int m, input logic [7:0] dest, input logic [7:0] here);
    int dy, dx, yd, xd;
    dy = int'(dest[7:4]) - int'(here[7:4]);
    dx = int'(dest[3:0]) - int'(here[3:0]);
    yd = (dy > 0) ? 0 : 1;
    xd = (dx > 0) ? 3 : 2;
    if (m == 0) return (dy != 0) ? yd : ((dx != 0) ? xd : 4);
    return (dx != 0) ? xd : ((dy != 0) ? yd : 4);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 5; i++) begin
        m_st[m][i] = 0; m_hop[m][i] = 0; m_own[m][i] = 0; m_ptr[m][i] = 4;
        m_blk[m][i] = 0; m_err[m][i] = 0; m_busy[m][i] = 0;
      end
  endtask

  task automatic model_step(input int m);
    bit gin[5];
    int best, bestd, d, r;
    for (int i = 0; i < 5; i++) gin[i] = 0;
    for (int o = 0; o < 5; o++) begin
      if (m_busy[m][o]) begin
        if (rel[m_own[m][o]]) m_busy[m][o] = 0;
      end else begin
        best = -1; bestd = 5;
        for (int i = 0; i < 5; i++) begin
          // distance from the slot after the pointer, wrapping round 5 ports
          d = (i - m_ptr[m][o] + 4) % 5;
          if (m_st[m][i] == 1 && m_hop[m][i] == o && req[i] && d < bestd) begin
            best = i; bestd = d;
          end
        end
        if (best >= 0) begin
          m_busy[m][o] = 1; m_own[m][o] = best; m_ptr[m][o] = best; gin[best] = 1;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      case (m_st[m][i])
        0: if (req[i] && !m_blk[m][i]) begin
             r = ref_route(m, hdr[i*8 +: 8], router);
             if (r == i && i != 4) begin m_err[m][i] = 1; m_blk[m][i] = 1; end
             else begin m_hop[m][i] = r; m_st[m][i] = 1; end
           end
        1: if (!req[i]) m_st[m][i] = 0; else if (gin[i]) m_st[m][i] = 2;
        default: if (rel[i]) m_st[m][i] = 0;
      endcase
      if (!req[i]) m_blk[m][i] = 0;
    end
  endtask

  task automatic model_check(input int m, input logic [24:0] g, input logic [4:0] ing,
                             input logic [4:0] bz, input logic [4:0] er);
    logic [24:0] eg;
    logic [4:0]  ei, eb, ee;
    eg = '0; ei = '0; eb = '0; ee = '0;
    for (int o = 0; o < 5; o++) begin
      if (m_busy[m][o]) eg[o*5 + m_own[m][o]] = 1'b1;
      eb[o] = m_busy[m][o];
      ei[o] = (m_st[m][o] == 2);
      ee[o] = m_err[m][o];
    end
    chk($sformatf("rand_gnt_m%0d", m), 32'(g), 32'(eg));
    chk($sformatf("rand_ing_m%0d", m), 32'(ing), 32'(ei));
    chk($sformatf("rand_busy_m%0d", m), 32'(bz), 32'(eb));
    chk($sformatf("rand_err_m%0d", m), 32'(er), 32'(ee));
  endtask

  typedef struct {
    logic [7:0] router;
    logic [7:0] hdr;
    int         inp;
    int         out_yx;
    int         out_xy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int order[5];
    int cyc, last, found;

    vecs[0]  = '{8'h22, 8'h31, 4, 0, 2};
    vecs[1]  = '{8'h22, 8'h33, 4, 0, 3};
    vecs[2]  = '{8'h22, 8'h13, 4, 1, 3};
    vecs[3]  = '{8'h22, 8'h22, 4, 4, 4};
    vecs[4]  = '{8'h22, 8'h32, 0, 7, 7};
    vecs[5]  = '{8'h22, 8'h11, 3, 1, 2};
    vecs[6]  = '{8'h59, 8'h50, 1, 2, 2};
    vecs[7]  = '{8'h00, 8'hff, 2, 0, 3};
    vecs[8]  = '{8'hff, 8'h00, 3, 1, 2};
    vecs[9]  = '{8'h22, 8'h23, 3, 7, 7};
    vecs[10] = '{8'h22, 8'h12, 1, 7, 7};

    reset = 1'b0; req = '0; rel = '0; hdr = '0; router = 8'h22;
    tick();
    chk("reset_gnt", 32'(gnt_yx | gnt_xy), 32'd0);
    chk("reset_busy", 32'(busy_yx | busy_xy), 32'd0);
    chk("reset_ing", 32'(ing_yx | ing_xy), 32'd0);
    chk("reset_err", 32'(err_yx | err_xy), 32'd0);

    // ---- routing table ----
    foreach (vecs[v]) begin
      do_reset();
      router = vecs[v].router;
      set_hdr(vecs[v].inp, vecs[v].hdr);
      req[vecs[v].inp] = 1'b1;
      tick();
      chk($sformatf("v%0d_lat1", v), 32'(gnt_yx | gnt_xy), 32'd0);
      tick();
      chk($sformatf("v%0d_gnt_yx", v), 32'(gnt_yx), exp_gnt(vecs[v].out_yx, vecs[v].inp));
      chk($sformatf("v%0d_gnt_xy", v), 32'(gnt_xy), exp_gnt(vecs[v].out_xy, vecs[v].inp));
      chk($sformatf("v%0d_err_yx", v), 32'(err_yx), exp_err(vecs[v].out_yx, vecs[v].inp));
      chk($sformatf("v%0d_err_xy", v), 32'(err_xy), exp_err(vecs[v].out_xy, vecs[v].inp));
      chk($sformatf("v%0d_ing_yx", v), 32'(ing_yx),
          (vecs[v].out_yx == 7) ? 32'd0 : (32'd1 << vecs[v].inp));
      chk($sformatf("v%0d_busy_yx", v), 32'(busy_yx),
          (vecs[v].out_yx == 7) ? 32'd0 : (32'd1 << vecs[v].out_yx));
      rel[vecs[v].inp] = 1'b1;
      tick();
      rel = '0;
      req = '0;
      chk($sformatf("v%0d_rel_gnt", v), 32'(gnt_yx | gnt_xy), 32'd0);
      chk($sformatf("v%0d_rel_busy", v), 32'(busy_yx | busy_xy | ing_yx | ing_xy), 32'd0);
      chk($sformatf("v%0d_err_sticky", v), 32'(err_yx), exp_err(vecs[v].out_yx, vecs[v].inp));
    end

    // ---- round-robin fairness on output N ----
    do_reset();
    for (int i = 1; i < 5; i++) begin
      set_hdr(i, 8'h32);
      req[i] = 1'b1;
    end
    order = '{1, 2, 3, 4, 1};
    cyc = 0; last = 0;
    for (int k = 0; k < 5; k++) begin
      found = 0;
      for (int w = 0; w < 12 && found == 0; w++) begin
        tick();
        cyc++;
        if (gnt_yx[4:0] != 5'd0) found = 1;
      end
      chk("fair_wait", 32'(found), 32'd1);
      chk($sformatf("fair_gnt%0d", k), 32'(gnt_yx), 32'd1 << order[k]);
      chk($sformatf("fair_gap%0d", k), 32'(cyc - last), 32'd2);
      last = cyc;
      rel[order[k]] = 1'b1;
      tick();
      cyc++;
      rel = '0;
    end
    req = '0;

    // ---- abort while output is locked ----
    do_reset();
    set_hdr(4, 8'h23);
    set_hdr(2, 8'h23);
    req[4] = 1'b1;
    tick();
    req[2] = 1'b1;
    tick();
    chk("lock_l_owns_e", 32'(gnt_yx), 32'd1 << 19);
    req[2] = 1'b0;
    tick();
    chk("lock_busy", 32'(busy_yx), 32'h08);
    rel[4] = 1'b1;
    req[4] = 1'b0;
    tick();
    rel = '0;
    for (int w = 0; w < 4; w++) begin
      chk("abort_no_gnt", 32'(gnt_yx | {27'd0, busy_yx}), 32'd0);
      tick();
    end
    req[2] = 1'b1;
    tick();
    tick();
    chk("abort_regrant", 32'(gnt_yx), 32'd1 << 17);
    req = '0;

    // ---- async reset mid-packet ----
    do_reset();
    set_hdr(4, 8'h23);
    set_hdr(1, 8'h32);
    req[4] = 1'b1;
    req[1] = 1'b1;
    tick();
    tick();
    chk("arst_two_busy", 32'(busy_yx), 32'h09);
    #2 reset = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt_yx | gnt_xy), 32'd0);
    chk("arst_busy", 32'(busy_yx | busy_xy | ing_yx), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("arst_lat1", 32'(gnt_yx), 32'd0);
    tick();
    chk("arst_regrant", 32'(gnt_yx), (32'd1 << 1) | (32'd1 << 19));
    req = '0;

    // ---- randomized against reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (req[i]) req[i] = ($urandom_range(0, 9) != 0);
        else        req[i] = ($urandom_range(0, 2) == 0);
        rel[i] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) == 0)
          set_hdr(i, {4'($urandom_range(1, 3)), 4'($urandom_range(1, 3))});
      end
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      model_check(0, gnt_yx, ing_yx, busy_yx, err_yx);
      model_check(1, gnt_xy, ing_xy, busy_xy, err_xy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
